// File: rtl/cp0_vec.sv
// Coprocessor 0 for the pipelined MIPS core: SR/Cause/EPC/PRId, vectored hardware
// interrupts, ERET and an optional Count/Compare timer enabled by CP0_TIMER_EN.
module cp0_vec #(
  parameter int          N_HWINT  = 5,
  parameter logic [31:0] PRID_VAL = 32'h84DD_0002,
  parameter int          CNT_DIV  = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [4:0]           rd,
  input  logic [31:0]          din,
  input  logic [31:0]          pc,
  input  logic                 in_bd,
  input  logic                 exc_valid,
  input  logic [4:0]           exc_code,
  input  logic [N_HWINT-1:0]   hw_int,
  input  logic                 eret,
  output logic                 handle,
  output logic [31:0]          epc_out,
  output logic [31:0]          dout,
  output logic [2:0]           int_idx,
  output logic                 timer_irq
);

  // Bit k of the 6-bit IM/IP vectors is architectural bit 10+k; bit 5 (IP7) is the timer.
  localparam logic [5:0] IM_MASK = 6'(((1 << N_HWINT) - 1) | 32'h20);

  logic [5:0]         im_reg;
  logic               exl_reg;
  logic               ie_reg;
  logic               bd_reg;
  logic [N_HWINT-1:0] ip_reg;
  logic [4:0]         exc_code_reg;
  logic [31:0]        epc_reg;

  logic [5:0]  ip_vec;
  logic [5:0]  pend;
  logic        int_req;
  logic        mtc0;
  logic        timer_bit;
  logic [31:0] epc_base;
  logic [31:0] epc_trap;

  genvar gi;
  generate
    for (gi = 0; gi < 5; gi = gi + 1) begin : g_ip
      if (gi < N_HWINT) begin : g_impl
        assign ip_vec[gi] = ip_reg[gi];
      end else begin : g_unimpl
        assign ip_vec[gi] = 1'b0;
      end
    end
  endgenerate
  assign ip_vec[5] = timer_bit;

  assign pend    = ip_vec & im_reg;
  assign int_req = (|pend) & ie_reg & ~exl_reg;
  assign handle  = exc_valid | int_req;
  assign mtc0    = we & ~handle;
  assign epc_out = epc_reg;

  assign epc_base = pc & 32'hFFFF_FFFC;
  assign epc_trap = in_bd ? (epc_base - 32'd4) : epc_base;

  // Priority only looks at IM so software can poll the index with interrupts disabled.
  always_comb begin
    int_idx = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (pend[i]) int_idx = 3'(i);
    end
    if (pend[5]) int_idx = 3'd5;
  end

`ifdef CP0_TIMER_EN
  logic [31:0] count_reg;
  logic [31:0] compare_reg;
  logic        timer_reg;
  logic        cnt_tick;
  logic        count_wr;

  assign count_wr = mtc0 && (rd == 5'd9);

  generate
    if (CNT_DIV == 0) begin : g_nodiv
      assign cnt_tick = 1'b1;
    end else begin : g_div
      logic [CNT_DIV-1:0] presc_reg;
      always_ff @(posedge clk) begin
        if (!reset || count_wr) presc_reg <= '0;
        else                    presc_reg <= presc_reg + 1'b1;
      end
      assign cnt_tick = &presc_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_reg   <= 32'd0;
      compare_reg <= 32'hFFFF_FFFF;
      timer_reg   <= 1'b0;
    end else begin
      if (count_wr)      count_reg <= din;
      else if (cnt_tick) count_reg <= count_reg + 32'd1;
      // A Compare write acknowledges the timer even if a match lands on the same edge.
      if (mtc0 && (rd == 5'd11)) begin
        compare_reg <= din;
        timer_reg   <= 1'b0;
      end else if (count_reg == compare_reg) begin
        timer_reg <= 1'b1;
      end
    end
  end

  assign timer_bit = timer_reg;
  assign timer_irq = timer_reg;
`else
  assign timer_bit = 1'b0;
  assign timer_irq = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      im_reg       <= 6'd0;
      exl_reg      <= 1'b0;
      ie_reg       <= 1'b0;
      bd_reg       <= 1'b0;
      ip_reg       <= '0;
      exc_code_reg <= 5'd0;
      epc_reg      <= 32'd0;
    end else begin
      ip_reg <= hw_int;
      if (handle) begin
        // The trapping instruction never commits, so its MTC0 is dropped.
        exl_reg      <= 1'b1;
        bd_reg       <= in_bd;
        epc_reg      <= epc_trap;
        exc_code_reg <= exc_valid ? exc_code : 5'd0;
      end else begin
        if (eret) exl_reg <= 1'b0;
        if (we) begin
          case (rd)
            5'd12: begin
              im_reg  <= din[15:10] & IM_MASK;
              exl_reg <= din[1];
              ie_reg  <= din[0];
            end
            5'd14:   epc_reg <= din;
            default: ;
          endcase
        end
      end
    end
  end

  always_comb begin
    dout = 32'd0;
    case (rd)
`ifdef CP0_TIMER_EN
      5'd9:  dout = count_reg;
      5'd11: dout = compare_reg;
`endif
      5'd12: dout = {16'd0, im_reg, 8'd0, exl_reg, ie_reg};
      5'd13: dout = {bd_reg, 15'd0, ip_vec, 3'd0, exc_code_reg, 2'd0};
      5'd14: dout = epc_reg;
      5'd15: dout = PRID_VAL;
      default: dout = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0_vec.sv
// Self-checking bench for cp0_vec: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cp0_vec;
  localparam int          N_HWINT = 5;
  localparam int          CNT_DIV = 0;
  localparam logic [31:0] PRID    = 32'h84DD_0002;

  logic               clk;
  logic               reset;
  logic               we;
  logic [4:0]         rd;
  logic [31:0]        din;
  logic [31:0]        pc;
  logic               in_bd;
  logic               exc_valid;
  logic [4:0]         exc_code;
  logic [N_HWINT-1:0] hw_int;
  logic               eret;
  logic               handle;
  logic [31:0]        epc_out;
  logic [31:0]        dout;
  logic [2:0]         int_idx;
  logic               timer_irq;

  cp0_vec #(.N_HWINT(N_HWINT), .PRID_VAL(PRID), .CNT_DIV(CNT_DIV)) dut (
    .clk(clk), .reset(reset), .we(we), .rd(rd), .din(din), .pc(pc),
    .in_bd(in_bd), .exc_valid(exc_valid), .exc_code(exc_code), .hw_int(hw_int),
    .eret(eret), .handle(handle), .epc_out(epc_out), .dout(dout),
    .int_idx(int_idx), .timer_irq(timer_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Behavioural model: architectural register values as plain variables.
  bit          m_valid = 0;
  bit [5:0]    m_im, m_ip;
  bit          m_exl, m_ie, m_bd, m_tp;
  bit [4:0]    m_exc;
  bit [31:0]   m_epc, m_count, m_compare;
  int          m_ticks;
  bit [5:0]    im_impl;

  function automatic logic [31:0] m_read(input logic [4:0] r, input bit [5:0] ipf);
    logic [31:0] v;
    v = 0;
    if (r == 12) v = (32'(m_im) << 10) | (32'(m_exl) << 1) | 32'(m_ie);
    if (r == 13) v = (32'(m_bd) << 31) | (32'(ipf) << 10) | (32'(m_exc) << 2);
    if (r == 14) v = m_epc;
    if (r == 15) v = PRID;
`ifdef CP0_TIMER_EN
    if (r == 9)  v = m_count;
    if (r == 11) v = m_compare;
`endif
    return v;
  endfunction

  initial begin
    bit [5:0]    ipf, pend;
    bit          e_handle, found, match;
    logic [2:0]  e_idx;
    logic [31:0] pcw;
    im_impl = 6'(((1 << N_HWINT) - 1) + 32);
    forever begin
      @(negedge clk);
      ipf = m_ip;
`ifdef CP0_TIMER_EN
      ipf[5] = m_tp;
`endif
      pend = ipf & m_im;
      e_handle = exc_valid || ((pend != 0) && m_ie && !m_exl);
      e_idx = 3'd7;
      found = 0;
      if (pend[5]) begin e_idx = 3'd5; found = 1; end
      for (int i = N_HWINT - 1; i >= 0; i--) begin
        if (!found && pend[i]) begin e_idx = 3'(i); found = 1; end
      end
      if (m_valid) begin
        chk("handle", handle, 32'(e_handle));
        chk("epc_out", epc_out, m_epc);
        chk("dout", dout, m_read(rd, ipf));
        chk("int_idx", 32'(int_idx), 32'(e_idx));
        chk("timer_irq", 32'(timer_irq), 32'(ipf[5]));
      end
      if (reset === 1'b0) begin
        m_valid = 1; m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_tp = 0;
        m_exc = 0; m_epc = 0; m_count = 0; m_compare = 32'hFFFF_FFFF; m_ticks = 0;
      end else if (m_valid) begin
        match = (m_count == m_compare);
        m_ip = 6'(hw_int);
`ifdef CP0_TIMER_EN
        if (we && !e_handle && rd == 9) begin
          m_count = din; m_ticks = 0;
        end else begin
          m_ticks++;
          if (m_ticks == (1 << CNT_DIV)) begin m_count++; m_ticks = 0; end
        end
        if (we && !e_handle && rd == 11) begin m_compare = din; m_tp = 0; end
        else if (match) m_tp = 1;
`endif
        if (e_handle) begin
          pcw = pc - (pc % 4);
          m_exl = 1; m_bd = in_bd;
          m_epc = in_bd ? pcw - 4 : pcw;
          m_exc = exc_valid ? exc_code : 0;
        end else begin
          if (eret) m_exl = 0;
          if (we && rd == 12) begin
            m_im = din[15:10] & im_impl; m_exl = din[1]; m_ie = din[0];
          end
          if (we && rd == 14) m_epc = din;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic at_neg();
    @(negedge clk); #2;
  endtask

  task automatic peek(input logic [4:0] r, input logic [31:0] exp, input string name);
    rd = r; #1;
    chk(name, dout, exp);
  endtask

  initial begin
    reset = 0; we = 0; rd = 0; din = 0; pc = 0; in_bd = 0;
    exc_valid = 0; exc_code = 0; hw_int = 0; eret = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1;
    // reset state
    at_neg;
    chk("rst_handle", 32'(handle), 0);
    chk("rst_idx", 32'(int_idx), 7);
    chk("rst_timer", 32'(timer_irq), 0);
    peek(12, 0, "rst_sr"); peek(13, 0, "rst_cause");
    peek(14, 0, "rst_epc"); peek(15, 32'h84DD_0002, "rst_prid");
    // interrupt line 0 taken one cycle after the pin rises
    step; we = 1; rd = 12; din = 32'h0000_0401; hw_int = 5'b00001; pc = 32'h100;
    step; we = 0; pc = 32'h0000_2000;
    at_neg;
    chk("irq0_handle", 32'(handle), 1);
    chk("irq0_idx", 32'(int_idx), 0);
    step; hw_int = 0; eret = 1;
    at_neg;
    chk("irq0_drop", 32'(handle), 0);
    peek(14, 32'h0000_2000, "irq0_epc"); peek(12, 32'h0000_0403, "irq0_sr");
    peek(13, 32'h0000_0400, "irq0_cause");
    step; eret = 0;
    at_neg;
    peek(12, 32'h0000_0401, "eret_sr");
    // exception in a delay slot
    step; exc_valid = 1; exc_code = 5'd4; in_bd = 1; pc = 32'h0000_3010;
    at_neg;
    chk("exc_handle", 32'(handle), 1);
    step; exc_valid = 0; exc_code = 0; in_bd = 0;
    at_neg;
    peek(14, 32'h0000_300C, "bd_epc"); peek(13, 32'h8000_0010, "bd_cause");
    peek(12, 32'h0000_0403, "bd_sr");
    // MTC0 suppressed on the trap cycle, ERET afterwards
    step; we = 1; rd = 14; din = 32'h1234_5678; exc_valid = 1; pc = 32'h0000_3000;
    at_neg;
    chk("sup_handle", 32'(handle), 1);
    step; we = 0; exc_valid = 0; eret = 1;
    at_neg;
    peek(14, 32'h0000_3000, "sup_epc"); peek(13, 32'h0000_0000, "sup_cause");
    step; eret = 0;
    at_neg;
    peek(12, 32'h0000_0401, "sup_sr");
    // priority with EXL set
    step; hw_int = 5'b01010; we = 1; rd = 12; din = 32'h0000_FC03;
    step; we = 0;
    at_neg;
    chk("exl_handle", 32'(handle), 0);
    chk("exl_idx", 32'(int_idx), 3);
    peek(12, 32'h0000_FC03, "exl_sr"); peek(13, 32'h0000_2800, "exl_cause");
    step; hw_int = 0; we = 1; rd = 12; din = 32'h0000_8001;
`ifdef CP0_TIMER_EN
    step; rd = 11; din = 32'd10;
    step; rd = 9; din = 32'd0;
    step; we = 0;
    for (int k = 1; k <= 11; k++) begin
      step;
      at_neg;
      chk($sformatf("tmr_irq_%0d", k), 32'(timer_irq), (k == 11) ? 1 : 0);
    end
    chk("tmr_handle", 32'(handle), 1);
    chk("tmr_idx", 32'(int_idx), 5);
    step; we = 1; rd = 11; din = 32'hFFFF_FFFF;
    at_neg;
    chk("tmr_sticky", 32'(timer_irq), 1);
    step; we = 0;
    at_neg;
    chk("tmr_clear", 32'(timer_irq), 0);
    peek(11, 32'hFFFF_FFFF, "tmr_cmp");
`else
    step; rd = 9; din = 32'h55;
    step; rd = 11; din = 32'd0;
    step; we = 0;
    at_neg;
    peek(9, 0, "notmr_count"); peek(11, 0, "notmr_cmp");
    chk("notmr_irq", 32'(timer_irq), 0);
    chk("notmr_idx", 32'(int_idx), 7);
`endif
    // randomized traffic; the model process checks every cycle
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rtab [8];
      rtab = '{5'd9, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'($urandom)};
      step;
      reset = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 3) == 0) hw_int = N_HWINT'($urandom);
      exc_valid = ($urandom_range(0, 9) == 0);
      exc_code = 5'($urandom);
      in_bd = 1'($urandom);
      pc = $urandom;
      eret = ($urandom_range(0, 9) == 0);
      we = !eret && ($urandom_range(0, 2) == 0);
      rd = rtab[$urandom_range(0, 7)];
      din = $urandom;
      if ((rd == 9 || rd == 11) && $urandom_range(0, 1) == 0) din = $urandom_range(0, 60);
      if (rd == 12 && $urandom_range(0, 3) != 0) din[1] = 1'b0;
    end
    step; reset = 1; we = 0; eret = 0; exc_valid = 0;
    repeat (3) step;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
